exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ds_to_es_valid  input  1  decode stage presents an instruction.
REQ-004 ds_to_es_bus  input  165  {pc[31:0], alu_op[11:0], src1[31:0], src2[31:0], div_op[3:0], ld_op[4:0], st_op[2:0], st_data[31:0], rf_we, rf_waddr[4:0], except[6:0]}, MSB first.
REQ-005 es_allowin  output  1  stage can accept an instruction this cycle.
REQ-006 ms_allowin  input  1  memory stage can accept.
REQ-007 es_to_ms_valid  output  1  stage valid and ready_go.
REQ-008 es_pc  output  32  PC of held instruction.
REQ-009 es_rf_collect  output  39  {res_from_mem, rf_we, rf_waddr[4:0], result[31:0]}.
REQ-010 mem_inst_bus  output  5  {ld_w, ld_h, ld_hu, ld_b, ld_bu}.
REQ-011 es_to_ms_bus  output  8  {wait_data_ok, except[6:0]}.
REQ-012 es_fwd  output  7  {es_valid & rf_we, es_is_load, rf_waddr[4:0]} for decode bypass/load-use stall.
REQ-013 data_sram_req / data_sram_wr  output  1/1  request valid; 1 = store.
REQ-014 data_sram_size / data_sram_wstrb  output  2/4  0/1/2 = byte/half/word; byte enables.
REQ-015 data_sram_addr / data_sram_wdata  output  32/32  byte address; lane-replicated store data.
REQ-016 data_sram_addr_ok  input  1  request accepted this cycle.
REQ-017 except_flush  input  1  pipeline flush; kills the held instruction.
REQ-018 ms_ex / wb_ex  input  1/1  a younger-than-commit exception sits downstream; suppresses memory requests.

Function
REQ-019 alu_op one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (result=src2); shifts use src2[4:0]; alu_op zero with no div_op gives result 0.
REQ-020 Memory address = src1+src2 (decode sets alu_op=add); res_from_mem = |ld_op.
REQ-021 ALE: ld_w/st_w with addr[1:0]!=0, or ld_h/ld_hu/st_h with addr[0]!=0, sets except bit 4; bits pass through OR'd with incoming except.
REQ-022 data_sram_req = es_valid & mem_op & ~req_sent & ~(|except) & ~ms_ex & ~wb_ex & ms_allowin; held until addr_ok; req_sent set on req & addr_ok, cleared when the instruction leaves or is flushed.
REQ-023 Store: st_b wstrb = 1<<addr[1:0], wdata = {4{b}}; st_h wstrb = 0011/1100 by addr[1], wdata = {2{h}}; st_w wstrb=1111; loads wstrb=0000.
REQ-024 wait_data_ok = req_sent at hand-off (memory op accepted, no exception).
REQ-025 ready_go: plain ALU = 1; mem op = req_sent | (req & addr_ok) | (|except) | ms_ex | wb_ex; div op = divider in DONE.
REQ-026 es_allowin = ~es_valid | (ready_go & ms_allowin); es_valid <= ds_to_es_valid & es_allowin, and 0 on except_flush; payload registers load only on ds_to_es_valid & es_allowin.
REQ-027 Divider FSM IDLE->BUSY->DONE->IDLE: enter BUSY on first cycle of a valid div op; one restoring radix-2 step per cycle, 32 cycles (counter 31 down to 0); DONE when counter wraps; IDLE on hand-off.
REQ-028 div_op {div_w, mod_w, div_wu, mod_wu}: signed ops divide magnitudes; quotient negated if sign(src1)!=sign(src2); remainder takes sign of src1.
REQ-029 Divide-by-zero: quotient 0xFFFFFFFF, remainder = src1; 0x80000000 / -1 signed: quotient 0x80000000, remainder 0.
REQ-030 except_flush at any time: es_valid=0, divider to IDLE, req_sent=0 next cycle; a flush in the same cycle as an incoming instruction keeps es_valid=0.
REQ-031 Divider result latency: 34 cycles from acceptance to es_to_ms_valid (1 load, 32 steps, 1 DONE).

Reset
REQ-032 On reset: es_valid=0, divider IDLE, counter 0, req_sent=0, all payload registers 0; hence es_to_ms_valid=0, data_sram_req=0, es_allowin=1, es_pc=0.

Verification
REQ-033 add src1=0x10 src2=0x20, ms_allowin=1 -> es_to_ms_valid next cycle, result 0x30, rf_we passes through.
REQ-034 st_h addr 0x1002, st_data 0xABCD, addr_ok delayed 3 cycles -> req held 3 cycles, wstrb=1100, wdata=0xABCDABCD, size=1, then hand-off with wait_data_ok=1.
REQ-035 ld_w addr 0x1001 -> no req, except bit4=1, wait_data_ok=0, hand-off next cycle.
REQ-036 div_w -7/2 -> quotient 0xFFFFFFFD after 34 cycles; mod_w -> 0xFFFFFFFF; div_wu x/0 -> 0xFFFFFFFF.
REQ-037 except_flush on cycle 10 of a divide -> es_valid=0 next cycle, FSM IDLE, following div completes in full 34 cycles.
REQ-038 wb_ex=1 with pending ld_b -> data_sram_req=0, stage hands off without a request.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: one-hot ALU, multi-cycle restoring divider, data-SRAM request
// generation with alignment checks, and valid/allowin handshaking to memory.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ds_to_es_valid,
    input  logic [164:0] ds_to_es_bus,
    output logic         es_allowin,
    input  logic         ms_allowin,
    output logic         es_to_ms_valid,
    output logic [31:0]  es_pc,
    output logic [38:0]  es_rf_collect,
    output logic [4:0]   mem_inst_bus,
    output logic [7:0]   es_to_ms_bus,
    output logic [6:0]   es_fwd,
    output logic         data_sram_req,
    output logic         data_sram_wr,
    output logic [1:0]   data_sram_size,
    output logic [3:0]   data_sram_wstrb,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    input  logic         data_sram_addr_ok,
    input  logic         except_flush,
    input  logic         ms_ex,
    input  logic         wb_ex
);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    // alu_op[0..11] = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
    // div_op = {div_w,mod_w,div_wu,mod_wu}; ld_op = {ld_w,ld_h,ld_hu,ld_b,ld_bu}; st_op = {st_w,st_h,st_b}
    logic        es_valid_q, es_valid_d;
    logic [31:0] pc_q, src1_q, src2_q, st_data_q;
    logic [11:0] alu_op_q;
    logic [3:0]  div_op_q;
    logic [4:0]  ld_op_q, rf_waddr_q;
    logic [2:0]  st_op_q;
    logic        rf_we_q;
    logic [6:0]  except_q;
    logic        req_sent_q, req_sent_d;

    div_state_t  div_state_q, div_state_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [31:0] div_rem_q, div_rem_d, div_quo_q, div_quo_d;

    logic        accept, handoff, ready_go;
    logic        is_div, mem_op, is_load, is_store, ale, exc_any;
    logic [31:0] add_res, alu_res, div_res, result;
    logic [6:0]  except_out;
    logic [4:0]  sh;

    assign accept  = ds_to_es_valid & es_allowin;
    assign handoff = es_to_ms_valid & ms_allowin;
    assign sh      = src2_q[4:0];
    assign add_res = src1_q + src2_q;

    assign alu_res = ({32{alu_op_q[0]}}  & add_res)
                   | ({32{alu_op_q[1]}}  & (src1_q - src2_q))
                   | ({32{alu_op_q[2]}}  & {31'd0, $signed(src1_q) < $signed(src2_q)})
                   | ({32{alu_op_q[3]}}  & {31'd0, src1_q < src2_q})
                   | ({32{alu_op_q[4]}}  & (src1_q & src2_q))
                   | ({32{alu_op_q[5]}}  & ~(src1_q | src2_q))
                   | ({32{alu_op_q[6]}}  & (src1_q | src2_q))
                   | ({32{alu_op_q[7]}}  & (src1_q ^ src2_q))
                   | ({32{alu_op_q[8]}}  & (src1_q << sh))
                   | ({32{alu_op_q[9]}}  & (src1_q >> sh))
                   | ({32{alu_op_q[10]}} & $unsigned($signed(src1_q) >>> sh))
                   | ({32{alu_op_q[11]}} & src2_q);

    // Divider works on magnitudes; signs are reapplied to the final result.
    logic        div_signed, src1_neg, src2_neg, step_ge;
    logic [31:0] a_mag, b_mag, sub_lo, quo_fin, rem_fin;
    logic [32:0] rem_shift;

    assign is_div     = |div_op_q;
    assign div_signed = div_op_q[3] | div_op_q[2];
    assign src1_neg   = div_signed & src1_q[31];
    assign src2_neg   = div_signed & src2_q[31];
    assign a_mag      = src1_neg ? (32'd0 - src1_q) : src1_q;
    assign b_mag      = src2_neg ? (32'd0 - src2_q) : src2_q;
    assign rem_shift  = {div_rem_q, div_quo_q[31]};
    assign step_ge    = rem_shift >= {1'b0, b_mag};
    assign sub_lo     = rem_shift[31:0] - b_mag;

    always_comb begin
        quo_fin = (src1_neg ^ src2_neg) ? (32'd0 - div_quo_q) : div_quo_q;
        rem_fin = src1_neg ? (32'd0 - div_rem_q) : div_rem_q;
        if (src2_q == 32'd0) begin
            quo_fin = 32'hFFFF_FFFF;
            rem_fin = src1_q;
        end
        div_res = (div_op_q[3] | div_op_q[1]) ? quo_fin : rem_fin;
        result  = is_div ? div_res : alu_res;
    end

    always_comb begin
        div_state_d = div_state_q;
        div_cnt_d   = div_cnt_q;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        if (except_flush) begin
            div_state_d = DIV_IDLE;
        end else begin
            case (div_state_q)
                DIV_IDLE: if (es_valid_q & is_div) begin
                    div_state_d = DIV_BUSY;
                    div_cnt_d   = 5'd31;
                    div_rem_d   = 32'd0;
                    div_quo_d   = a_mag;
                end
                DIV_BUSY: begin
                    div_cnt_d = div_cnt_q - 5'd1;
                    div_rem_d = step_ge ? sub_lo : rem_shift[31:0];
                    div_quo_d = {div_quo_q[30:0], step_ge};
                    if (div_cnt_q == 5'd0) div_state_d = DIV_DONE;
                end
                DIV_DONE: if (handoff) div_state_d = DIV_IDLE;
                default:  div_state_d = DIV_IDLE;
            endcase
        end
    end

    assign is_load    = |ld_op_q;
    assign is_store   = |st_op_q;
    assign mem_op     = is_load | is_store;
    assign ale        = ((ld_op_q[4] | st_op_q[2]) & (add_res[1:0] != 2'b00))
                      | ((ld_op_q[3] | ld_op_q[2] | st_op_q[1]) & add_res[0]);
    assign except_out = except_q | {2'b00, ale, 4'b0000};
    assign exc_any    = |except_out;

    assign data_sram_req = es_valid_q & mem_op & ~req_sent_q & ~exc_any & ~ms_ex & ~wb_ex & ms_allowin;

    always_comb begin
        ready_go = 1'b1;
        if (is_div)
            ready_go = (div_state_q == DIV_DONE);
        else if (mem_op)
            ready_go = req_sent_q | (data_sram_req & data_sram_addr_ok) | exc_any | ms_ex | wb_ex;
    end

    assign es_to_ms_valid = es_valid_q & ready_go;
    assign es_allowin     = ~es_valid_q | (ready_go & ms_allowin);

    always_comb begin
        es_valid_d = es_valid_q;
        if (except_flush)    es_valid_d = 1'b0;
        else if (es_allowin) es_valid_d = ds_to_es_valid;
        req_sent_d = req_sent_q;
        if (except_flush | handoff)                   req_sent_d = 1'b0;
        else if (data_sram_req & data_sram_addr_ok)   req_sent_d = 1'b1;
    end

    always_comb begin
        data_sram_size = 2'd2;
        if (st_op_q[0] | ld_op_q[1] | ld_op_q[0])      data_sram_size = 2'd0;
        else if (st_op_q[1] | ld_op_q[3] | ld_op_q[2]) data_sram_size = 2'd1;
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = st_data_q;
        if (st_op_q[0]) begin
            data_sram_wstrb = 4'b0001 << add_res[1:0];
            data_sram_wdata = {4{st_data_q[7:0]}};
        end else if (st_op_q[1]) begin
            data_sram_wstrb = add_res[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{st_data_q[15:0]}};
        end else if (st_op_q[2]) begin
            data_sram_wstrb = 4'b1111;
        end
    end

    assign data_sram_wr   = is_store;
    assign data_sram_addr = add_res;
    assign es_pc          = pc_q;
    assign es_rf_collect  = {is_load, rf_we_q, rf_waddr_q, result};
    assign mem_inst_bus   = ld_op_q;
    assign es_to_ms_bus   = {req_sent_q | (data_sram_req & data_sram_addr_ok), except_out};
    assign es_fwd         = {es_valid_q & rf_we_q, es_valid_q & is_load, rf_waddr_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q  <= 1'b0;
            req_sent_q  <= 1'b0;
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= 5'd0;
            div_rem_q   <= 32'd0;
            div_quo_q   <= 32'd0;
            pc_q        <= 32'd0;
            alu_op_q    <= 12'd0;
            src1_q      <= 32'd0;
            src2_q      <= 32'd0;
            div_op_q    <= 4'd0;
            ld_op_q     <= 5'd0;
            st_op_q     <= 3'd0;
            st_data_q   <= 32'd0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 5'd0;
            except_q    <= 7'd0;
        end else begin
            es_valid_q  <= es_valid_d;
            req_sent_q  <= req_sent_d;
            div_state_q <= div_state_d;
            div_cnt_q   <= div_cnt_d;
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            if (accept) begin
                {pc_q, alu_op_q, src1_q, src2_q, div_op_q, ld_op_q, st_op_q,
                 st_data_q, rf_we_q, rf_waddr_q, except_q} <= ds_to_es_bus;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed and randomized checks of exe_stage against a behavioural reference model.
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         reset, ds_to_es_valid, ms_allowin, data_sram_addr_ok, except_flush, ms_ex, wb_ex;
    logic [164:0] ds_to_es_bus;
    logic         es_allowin, es_to_ms_valid, data_sram_req, data_sram_wr;
    logic [31:0]  es_pc, data_sram_addr, data_sram_wdata;
    logic [38:0]  es_rf_collect;
    logic [4:0]   mem_inst_bus;
    logic [7:0]   es_to_ms_bus;
    logic [6:0]   es_fwd;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_allowin(es_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc),
        .es_rf_collect(es_rf_collect), .mem_inst_bus(mem_inst_bus),
        .es_to_ms_bus(es_to_ms_bus), .es_fwd(es_fwd),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .except_flush(except_flush),
        .ms_ex(ms_ex), .wb_ex(wb_ex)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [164:0] mk(input logic [31:0] pc, input logic [11:0] alu,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [3:0] dv, input logic [4:0] ld,
                                        input logic [2:0] st, input logic [31:0] sd,
                                        input logic we, input logic [4:0] wa);
        return {pc, alu, s1, s2, dv, ld, st, sd, we, wa, 7'd0};
    endfunction

    // Reference: ALU by operation index 0..11, divider by kind 0..3 (div_w, mod_w, div_wu, mod_wu).
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return 32'(sa >>> b[4:0]);
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] ref_div(input int kind, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        bit want_q;
        want_q = (kind % 2) == 0;
        sa = a; sb = b;
        if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
        if (kind < 2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_q ? 32'h8000_0000 : 32'd0;
            return want_q ? 32'(sa / sb) : 32'(sa % sb);
        end
        return want_q ? (a / b) : (a % b);
    endfunction

    task automatic send(input logic [164:0] b);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
    endtask

    // Counts cycles after acceptance until es_to_ms_valid; bounded by maxc.
    task automatic wait_out(input int maxc, output int n);
        n = 1;
        @(negedge clk);
        while (!es_to_ms_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic retire();
        @(posedge clk); #1;
    endtask

    // kind 0..11 = ALU op, 12..15 = divide kinds
    task automatic run_op(input string tag, input int kind, input logic [31:0] a, input logic [31:0] b);
        logic [11:0] alu;
        logic [3:0]  dv;
        logic [31:0] exp;
        int n, lat;
        alu = 12'd0; dv = 4'd0;
        if (kind < 12) begin
            alu = 12'd1 << kind; exp = ref_alu(kind, a, b); lat = 1;
        end else begin
            dv = 4'b1000 >> (kind - 12); exp = ref_div(kind - 12, a, b); lat = 34;
        end
        send(mk(32'h1c00_0000 + kind, alu, a, b, dv, 5'd0, 3'd0, 32'd0, 1'b1, 5'd3));
        wait_out(60, n);
        $display("txn %s kind=%0d a=%h b=%h res=%h lat=%0d", tag, kind, a, b, es_rf_collect[31:0], n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_res"}, es_rf_collect[31:0], exp);
        retire();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, nb;
        logic [31:0] a, b, d, addr;
        logic [4:0] ld;
        logic [2:0] st;
        logic [3:0] exp_strb;

        reset = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0; ms_allowin = 1'b1;
        data_sram_addr_ok = 1'b0; except_flush = 1'b0; ms_ex = 1'b0; wb_ex = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", es_to_ms_valid, 1'b0);
        check("rst_req", data_sram_req, 1'b0);
        check("rst_allowin", es_allowin, 1'b1);
        check("rst_pc", es_pc, 32'd0);
        @(posedge clk); #1;

        // add, single-cycle hand-off
        send(mk(32'h1c00_0100, 12'd1, 32'h10, 32'h20, 4'd0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd5));
        @(negedge clk);
        $display("txn add res=%h", es_rf_collect[31:0]);
        check("add_valid", es_to_ms_valid, 1'b1);
        check("add_res", es_rf_collect[31:0], 32'h30);
        check("add_we", es_rf_collect[37], 1'b1);
        check("add_pc", es_pc, 32'h1c00_0100);
        check("add_fwd", es_fwd, 7'b1_0_00101);
        retire();
        @(negedge clk);
        check("add_gone", es_to_ms_valid, 1'b0);

        // stall from memory stage holds the instruction
        #1 ms_allowin = 1'b0;
        send(mk(32'h1c00_0104, 12'd1, 32'd1, 32'd2, 4'd0, 5'd0, 3'd0, 32'd0, 1'b0, 5'd0));
        @(negedge clk);
        check("stall_allowin", es_allowin, 1'b0);
        check("stall_valid", es_to_ms_valid, 1'b1);
        @(posedge clk); #1 ms_allowin = 1'b1;
        retire();

        // st_h with addr_ok delayed by three cycles
        send(mk(32'h1c00_0200, 12'd1, 32'h1000, 32'h2, 4'd0, 5'd0, 3'b010, 32'h0000_ABCD, 1'b0, 5'd0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sth_req_held", data_sram_req, 1'b1);
            check("sth_not_ready", es_to_ms_valid, 1'b0);
            @(posedge clk); #1;
        end
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        $display("txn st_h addr=%h wstrb=%b wdata=%h", data_sram_addr, data_sram_wstrb, data_sram_wdata);
        check("sth_req", data_sram_req, 1'b1);
        check("sth_wr", data_sram_wr, 1'b1);
        check("sth_addr", data_sram_addr, 32'h1002);
        check("sth_wstrb", data_sram_wstrb, 4'b1100);
        check("sth_wdata", data_sram_wdata, 32'hABCD_ABCD);
        check("sth_size", data_sram_size, 2'd1);
        check("sth_handoff", es_to_ms_valid, 1'b1);
        check("sth_wait_data_ok", es_to_ms_bus[7], 1'b1);
        @(posedge clk); #1 data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check("sth_req_clear", data_sram_req, 1'b0);
        @(posedge clk); #1;

        // misaligned ld_w raises ALE and skips the request
        send(mk(32'h1c00_0300, 12'd1, 32'h1000, 32'h1, 4'd0, 5'b10000, 3'd0, 32'd0, 1'b1, 5'd7));
        @(negedge clk);
        $display("txn ld_w_ale bus=%h", es_to_ms_bus);
        check("ale_req", data_sram_req, 1'b0);
        check("ale_bus", es_to_ms_bus, 8'h10);
        check("ale_valid", es_to_ms_valid, 1'b1);
        check("ale_res_from_mem", es_rf_collect[38], 1'b1);
        retire();

        // wb_ex pending suppresses a load request
        wb_ex = 1'b1;
        send(mk(32'h1c00_0400, 12'd1, 32'h2000, 32'h3, 4'd0, 5'b00010, 3'd0, 32'd0, 1'b1, 5'd8));
        @(negedge clk);
        $display("txn ld_b_wbex req=%b", data_sram_req);
        check("wbex_req", data_sram_req, 1'b0);
        check("wbex_valid", es_to_ms_valid, 1'b1);
        check("wbex_wdok", es_to_ms_bus[7], 1'b0);
        retire();
        wb_ex = 1'b0;

        // directed divides
        run_op("div_w", 12, 32'hFFFF_FFF9, 32'd2);
        run_op("mod_w", 13, 32'hFFFF_FFF9, 32'd2);
        run_op("div_wu0", 14, 32'h1234_5678, 32'd0);
        run_op("div_w_ovf", 12, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mod_w0", 13, 32'hFFFF_FF00, 32'd0);

        // flush on cycle 10 of a divide
        send(mk(32'h1c00_0500, 12'd0, 32'd100, 32'd7, 4'b1000, 5'd0, 3'd0, 32'd0, 1'b1, 5'd9));
        repeat (9) begin @(posedge clk); #1; end
        except_flush = 1'b1;
        @(posedge clk); #1 except_flush = 1'b0;
        @(negedge clk);
        $display("txn div_flush allowin=%b", es_allowin);
        check("flush_valid", es_to_ms_valid, 1'b0);
        check("flush_allowin", es_allowin, 1'b1);
        check("flush_fwd", es_fwd[6], 1'b0);
        @(posedge clk); #1;
        run_op("div_after_flush", 12, 32'd100, 32'd7);

        // flush coinciding with an incoming instruction
        except_flush = 1'b1;
        send(mk(32'h1c00_0600, 12'd1, 32'd1, 32'd1, 4'd0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd1));
        except_flush = 1'b0;
        @(negedge clk);
        check("flush_in_valid", es_to_ms_valid, 1'b0);
        check("flush_in_allowin", es_allowin, 1'b1);
        @(posedge clk); #1;

        // random ALU and divide operations
        for (int i = 0; i < 40; i++) begin
            a = pick(); b = pick();
            t = $urandom_range(0, 15);
            run_op("rnd", t, a, b);
        end

        // random loads and stores, immediate addr_ok
        data_sram_addr_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            t = $urandom_range(0, 5);
            nb = (t % 3 == 0) ? 1 : ((t % 3 == 1) ? 2 : 4);
            addr = 32'h0000_4000 + $urandom_range(0, 255);
            d = $urandom;
            st = 3'd0; ld = 5'd0;
            if (t < 3) st = (nb == 1) ? 3'b001 : ((nb == 2) ? 3'b010 : 3'b100);
            else       ld = (nb == 1) ? 5'b00010 : ((nb == 2) ? 5'b01000 : 5'b10000);
            send(mk(32'h1c00_0700, 12'd1, addr - 32'd16, 32'd16, 4'd0, ld, st, d, ld != 0, 5'd4));
            @(negedge clk);
            $display("txn mem t=%0d addr=%h req=%b wstrb=%b wdata=%h", t, data_sram_addr, data_sram_req,
                     data_sram_wstrb, data_sram_wdata);
            check("mem_valid", es_to_ms_valid, 1'b1);
            check("mem_addr", data_sram_addr, addr);
            if ((addr % nb) != 0) begin
                check("mem_ale_req", data_sram_req, 1'b0);
                check("mem_ale_bus", es_to_ms_bus, 8'h10);
            end else begin
                exp_strb = (t >= 3) ? 4'd0 : ((nb == 4) ? 4'hF : 4'((((1 << nb) - 1) << (addr % 4))));
                check("mem_req", data_sram_req, 1'b1);
                check("mem_wr", data_sram_wr, t < 3);
                check("mem_size", data_sram_size, (nb == 1) ? 2'd0 : ((nb == 2) ? 2'd1 : 2'd2));
                check("mem_wstrb", data_sram_wstrb, exp_strb);
                check("mem_wdok", es_to_ms_bus, 8'h80);
                if (t < 3)
                    check("mem_wdata", data_sram_wdata,
                          (nb == 1) ? d[7:0] * 32'h0101_0101 : ((nb == 2) ? d[15:0] * 32'h0001_0001 : d));
                else
                    check("mem_ldbus", mem_inst_bus, ld);
            end
            retire();
        end
        data_sram_addr_ok = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
